// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//    Shares one RAM port between the instruction cache (I) and the data cache
//    (D). A registered grant (owner) selects which cache drives the RAM port.
//    D has priority. After STARVE_LIMIT back-to-back D completions, a waiting I
//    request wins the next arbitration. The owner's request, address and data
//    pass through to the RAM combinationally. The RAM completion pulse
//    (ram_ready) is routed back as a one-cycle low on the owner's wait line,
//    together with the RAM read data.
//
// Parameters:
//    STARVE_LIMIT  D completions tolerated while I waits (>= 1)
//
// Ports:
//    CLK        in   clock, rising edge
//    RST        in   synchronous reset, active high
//    iREN       in   icache read request
//    iaddr      in   icache word address
//    iload      out  read data to icache (valid while iwait is low)
//    iwait      out  low only in the completing cycle of an I access
//    dREN       in   dcache read request
//    dWEN       in   dcache write request (wins over dREN)
//    daddr      in   dcache word address
//    dstore     in   dcache write data
//    dload      out  read data to dcache (valid while dwait is low)
//    dwait      out  low only in the completing cycle of a D access
//    ramREN     out  RAM read strobe
//    ramWEN     out  RAM write strobe
//    ramaddr    out  RAM address
//    ramstore   out  RAM write data
//    ramload    in   RAM read data, valid with ram_ready
//    ram_ready  in   one-cycle pulse: the current RAM access completes
//    owner      out  registered grant: 0 = none, 1 = I, 2 = D
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ram_ready,
   output logic [1:0]  owner
);

   localparam int              CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   owner_t          r_owner;
   owner_t          w_owner_next;
   logic [CW-1:0]   r_consec_d;
   logic [CW-1:0]   w_consec_next;
   logic            w_dreq;
   logic            w_starved;

   assign w_dreq    = dREN | dWEN;
   // Uses the registered count only; a completion in flight does not count yet.
   assign w_starved = (r_consec_d >= LIMIT);
   assign owner     = r_owner;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_owner    <= OWN_NONE;
         r_consec_d <= '0;
      end else begin
         r_owner    <= w_owner_next;
         r_consec_d <= w_consec_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      w_owner_next  = r_owner;
      w_consec_next = r_consec_d;
      ramREN        = 1'b0;
      ramWEN        = 1'b0;
      ramaddr       = '0;
      ramstore      = '0;
      iwait         = 1'b1;
      dwait         = 1'b1;
      iload         = '0;
      dload         = '0;

      // Reset masks the outputs too, so a ram_ready arriving in the same
      // cycle as reset can never be reported as a completion.
      if (!RST) begin
         case (r_owner)
            OWN_NONE: begin
               if (w_dreq && iREN && w_starved) begin
                  w_owner_next = OWN_I;
               end else if (w_dreq) begin
                  w_owner_next = OWN_D;
               end else if (iREN) begin
                  w_owner_next = OWN_I;
               end else begin
                  w_owner_next = OWN_NONE;
               end
            end

            OWN_I: begin
               ramREN  = iREN;
               ramaddr = iaddr;
               if (!iREN) begin
                  // Request withdrawn: release the port silently.
                  w_owner_next = OWN_NONE;
               end else if (ram_ready) begin
                  iwait         = 1'b0;
                  iload         = ramload;
                  w_owner_next  = OWN_NONE;
                  w_consec_next = '0;
               end
            end

            OWN_D: begin
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (!w_dreq) begin
                  w_owner_next = OWN_NONE;
               end else if (ram_ready) begin
                  dwait        = 1'b0;
                  dload        = ramload;
                  w_owner_next = OWN_NONE;
                  if (r_consec_d < LIMIT) begin
                     w_consec_next = r_consec_d + 1'b1;
                  end
               end
            end

            default: begin
               w_owner_next = OWN_NONE;
            end
         endcase
      end
   end

endmodule
